// File: rtl/watch_time_core.sv
// watch_time_core
//   Calendar/time-of-day counter for a watch. Advances by one second on each
//   rising edge of the 1 Hz divider level (detected in the clk domain), rolls
//   the carry chain through minute/hour/day/month/year with Gregorian leap
//   years, and accepts a clamped binary load from the set-mode block.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   clk1sec    in   1 Hz level from the divider
//   pause      in   1 = ignore seconds ticks
//   en_time    in   one-cycle load strobe
//   bin_time   in   {year[11:0], month, day, hour, minute, second} binary
//   year..second out current time, binary, registered
//   sec_pulse  out  one cycle per accepted tick
//   day_pulse  out  one cycle on midnight rollover (with sec_pulse)
module watch_time_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk1sec,
    input  logic        pause,
    input  logic        en_time,
    input  logic [51:0] bin_time,
    output logic [11:0] year,
    output logic [7:0]  month,
    output logic [7:0]  day,
    output logic [7:0]  hour,
    output logic [7:0]  minute,
    output logic [7:0]  second,
    output logic        sec_pulse,
    output logic        day_pulse
);

    function automatic logic f_leap(input logic [11:0] y);
        return ((y % 12'd4 == 12'd0) && (y % 12'd100 != 12'd0)) || (y % 12'd400 == 12'd0);
    endfunction

    function automatic logic [7:0] f_max_date(input logic [7:0] m, input logic [11:0] y);
        logic [7:0] md;
        case (m)
            8'd4, 8'd6, 8'd9, 8'd11: md = 8'd30;
            8'd2:                    md = f_leap(y) ? 8'd29 : 8'd28;
            default:                 md = 8'd31;
        endcase
        return md;
    endfunction

    logic        r_s1, r_s2;
    logic [11:0] r_year;
    logic [7:0]  r_month, r_day, r_hour, r_minute, r_second;
    logic        r_sec_pulse, r_day_pulse;

    logic        w_tick;
    logic [11:0] w_ld_year;
    logic [7:0]  w_ld_month, w_ld_day, w_ld_hour, w_ld_minute, w_ld_second;
    logic [7:0]  w_ld_max;
    logic [11:0] w_nx_year;
    logic [7:0]  w_nx_month, w_nx_day, w_nx_hour, w_nx_minute, w_nx_second;
    logic [7:0]  w_cur_max;
    logic        w_midnight;

    assign w_tick = r_s1 & ~r_s2;

    // Load path: clamp each field; day limit uses the clamped load, not the registers.
    always_comb begin
        w_ld_year   = bin_time[51:40];
        w_ld_month  = bin_time[39:32];
        w_ld_day    = bin_time[31:24];
        w_ld_hour   = bin_time[23:16];
        w_ld_minute = bin_time[15:8];
        w_ld_second = bin_time[7:0];
        if (w_ld_year == 12'd0)   w_ld_year   = 12'd1;
        if (w_ld_month == 8'd0)   w_ld_month  = 8'd1;
        if (w_ld_month > 8'd12)   w_ld_month  = 8'd12;
        if (w_ld_hour > 8'd23)    w_ld_hour   = 8'd23;
        if (w_ld_minute > 8'd59)  w_ld_minute = 8'd59;
        if (w_ld_second > 8'd59)  w_ld_second = 8'd59;
        w_ld_max = f_max_date(w_ld_month, w_ld_year);
        if (w_ld_day == 8'd0)     w_ld_day    = 8'd1;
        if (w_ld_day > w_ld_max)  w_ld_day    = w_ld_max;
    end

    // Advance-by-one-second path with the full carry chain.
    always_comb begin
        w_nx_year   = r_year;
        w_nx_month  = r_month;
        w_nx_day    = r_day;
        w_nx_hour   = r_hour;
        w_nx_minute = r_minute;
        w_nx_second = r_second;
        w_midnight  = 1'b0;
        w_cur_max   = f_max_date(r_month, r_year);
        if (r_second >= 8'd59) begin
            w_nx_second = 8'd0;
            if (r_minute >= 8'd59) begin
                w_nx_minute = 8'd0;
                if (r_hour >= 8'd23) begin
                    w_nx_hour  = 8'd0;
                    w_midnight = 1'b1;
                    if (r_day >= w_cur_max) begin
                        w_nx_day = 8'd1;
                        if (r_month >= 8'd12) begin
                            w_nx_month = 8'd1;
                            // Year wraps past 4095 to 1; year 0 is never produced.
                            w_nx_year  = (r_year == 12'd4095) ? 12'd1 : r_year + 12'd1;
                        end else begin
                            w_nx_month = r_month + 8'd1;
                        end
                    end else begin
                        w_nx_day = r_day + 8'd1;
                    end
                end else begin
                    w_nx_hour = r_hour + 8'd1;
                end
            end else begin
                w_nx_minute = r_minute + 8'd1;
            end
        end else begin
            w_nx_second = r_second + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_year      <= 12'd2000;
            r_month     <= 8'd1;
            r_day       <= 8'd1;
            r_hour      <= 8'd0;
            r_minute    <= 8'd0;
            r_second    <= 8'd0;
            r_sec_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
        end else begin
            // Synchronisers keep sampling while paused so release makes no burst tick.
            r_s1        <= clk1sec;
            r_s2        <= r_s1;
            r_sec_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
            if (en_time) begin
                r_year   <= w_ld_year;
                r_month  <= w_ld_month;
                r_day    <= w_ld_day;
                r_hour   <= w_ld_hour;
                r_minute <= w_ld_minute;
                r_second <= w_ld_second;
            end else if (w_tick && !pause) begin
                r_year      <= w_nx_year;
                r_month     <= w_nx_month;
                r_day       <= w_nx_day;
                r_hour      <= w_nx_hour;
                r_minute    <= w_nx_minute;
                r_second    <= w_nx_second;
                r_sec_pulse <= 1'b1;
                r_day_pulse <= w_midnight;
            end
        end
    end

    assign year      = r_year;
    assign month     = r_month;
    assign day       = r_day;
    assign hour      = r_hour;
    assign minute    = r_minute;
    assign second    = r_second;
    assign sec_pulse = r_sec_pulse;
    assign day_pulse = r_day_pulse;

endmodule

// File: tb/tb_watch_time_core.sv
// Self-checking bench for watch_time_core: reset, tick counting, a table of
// load/tick vectors covering carries, leap years and clamping, and hand-written
// sequences for load/tick collision, pause and mid-operation reset.
module tb_watch_time_core;

    typedef struct packed {
        logic [11:0] y;
        logic [7:0]  mo;
        logic [7:0]  d;
        logic [7:0]  h;
        logic [7:0]  mi;
        logic [7:0]  s;
        logic        sp;
        logic        dp;
    } exp_t;

    typedef struct {
        string       name;
        logic [51:0] bin;
        exp_t        ld;
        exp_t        tk;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk1sec = 1'b0;
    logic        pause = 1'b0;
    logic        en_time = 1'b0;
    logic [51:0] bin_time = '0;
    logic [11:0] year;
    logic [7:0]  month, day, hour, minute, second;
    logic        sec_pulse, day_pulse;

    int   total = 0;
    int   bad = 0;
    exp_t sb_q[$];
    vec_t vecs[12];

    watch_time_core dut (
        .clk       (clk),
        .rst       (rst),
        .clk1sec   (clk1sec),
        .pause     (pause),
        .en_time   (en_time),
        .bin_time  (bin_time),
        .year      (year),
        .month     (month),
        .day       (day),
        .hour      (hour),
        .minute    (minute),
        .second    (second),
        .sec_pulse (sec_pulse),
        .day_pulse (day_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got=running want=finished");
        $fatal(1, "timeout");
    end

    function automatic exp_t mk(int y, int mo, int d, int h, int mi, int s, int sp, int dp);
        exp_t e;
        e.y  = 12'(y);
        e.mo = 8'(mo);
        e.d  = 8'(d);
        e.h  = 8'(h);
        e.mi = 8'(mi);
        e.s  = 8'(s);
        e.sp = 1'(sp);
        e.dp = 1'(dp);
        return e;
    endfunction

    function automatic logic [51:0] mkbin(int y, int mo, int d, int h, int mi, int s);
        return {12'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
    endfunction

    function automatic exp_t nopulse(exp_t e);
        exp_t r = e;
        r.sp = 1'b0;
        r.dp = 1'b0;
        return r;
    endfunction

    function automatic string fmt(exp_t e);
        return $sformatf("%0d-%0d-%0d %0d:%0d:%0d sp=%0d dp=%0d",
                         e.y, e.mo, e.d, e.h, e.mi, e.s, e.sp, e.dp);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pop the next expected record and compare against the DUT outputs.
    task automatic check(input string name);
        exp_t want;
        exp_t got;
        got = {year, month, day, hour, minute, second, sec_pulse, day_pulse};
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, got=%s", name, fmt(got));
        end else begin
            want = sb_q.pop_front();
            if (got !== want) begin
                bad++;
                $display("FAIL %s: got=%s want=%s", name, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic do_load(input logic [51:0] b, input exp_t want, input string name);
        en_time  = 1'b1;
        bin_time = b;
        sb_q.push_back(want);
        step();
        en_time = 1'b0;
        check(name);
    endtask

    // One clk1sec rise; check right after the advancing edge, then the pulse-free cycle.
    task automatic do_tick(input exp_t want, input string name);
        clk1sec = 1'b1;
        step();
        sb_q.push_back(want);
        step();
        check(name);
        clk1sec = 1'b0;
        sb_q.push_back(nopulse(want));
        step();
        check({name, "_after"});
        step();
    endtask

    initial begin
        vecs[0]  = '{"ny_rollover",  mkbin(2023, 12, 31, 23, 59, 59),
                     mk(2023, 12, 31, 23, 59, 59, 0, 0), mk(2024, 1, 1, 0, 0, 0, 1, 1)};
        vecs[1]  = '{"leap_2024",    mkbin(2024, 2, 28, 23, 59, 59),
                     mk(2024, 2, 28, 23, 59, 59, 0, 0), mk(2024, 2, 29, 0, 0, 0, 1, 1)};
        vecs[2]  = '{"noleap_2100",  mkbin(2100, 2, 28, 23, 59, 59),
                     mk(2100, 2, 28, 23, 59, 59, 0, 0), mk(2100, 3, 1, 0, 0, 0, 1, 1)};
        vecs[3]  = '{"leap_2000",    mkbin(2000, 2, 28, 23, 59, 59),
                     mk(2000, 2, 28, 23, 59, 59, 0, 0), mk(2000, 2, 29, 0, 0, 0, 1, 1)};
        vecs[4]  = '{"clamp_all",    mkbin(2023, 13, 40, 30, 75, 60),
                     mk(2023, 12, 31, 23, 59, 59, 0, 0), mk(2024, 1, 1, 0, 0, 0, 1, 1)};
        vecs[5]  = '{"clamp_apr31",  mkbin(2023, 4, 31, 10, 20, 30),
                     mk(2023, 4, 30, 10, 20, 30, 0, 0), mk(2023, 4, 30, 10, 20, 31, 1, 0)};
        vecs[6]  = '{"clamp_year0",  mkbin(0, 0, 0, 0, 0, 0),
                     mk(1, 1, 1, 0, 0, 0, 0, 0), mk(1, 1, 1, 0, 0, 1, 1, 0)};
        vecs[7]  = '{"year_wrap",    mkbin(4095, 12, 31, 23, 59, 59),
                     mk(4095, 12, 31, 23, 59, 59, 0, 0), mk(1, 1, 1, 0, 0, 0, 1, 1)};
        vecs[8]  = '{"hour_carry",   mkbin(2023, 6, 30, 12, 59, 59),
                     mk(2023, 6, 30, 12, 59, 59, 0, 0), mk(2023, 6, 30, 13, 0, 0, 1, 0)};
        vecs[9]  = '{"feb30_leap",   mkbin(2024, 2, 30, 23, 59, 59),
                     mk(2024, 2, 29, 23, 59, 59, 0, 0), mk(2024, 3, 1, 0, 0, 0, 1, 1)};
        vecs[10] = '{"feb29_noleap", mkbin(2023, 2, 29, 23, 59, 59),
                     mk(2023, 2, 28, 23, 59, 59, 0, 0), mk(2023, 3, 1, 0, 0, 0, 1, 1)};
        vecs[11] = '{"nov30",        mkbin(2023, 11, 30, 23, 59, 59),
                     mk(2023, 11, 30, 23, 59, 59, 0, 0), mk(2023, 12, 1, 0, 0, 0, 1, 1)};

        // Reset state.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        sb_q.push_back(mk(2000, 1, 1, 0, 0, 0, 0, 0));
        check("reset");

        // Three ticks from reset.
        for (int i = 1; i <= 3; i++) begin
            do_tick(mk(2000, 1, 1, 0, 0, i, 1, 0), $sformatf("count_%0d", i));
        end

        // Table of load-then-tick vectors.
        for (int i = 0; i < 12; i++) begin
            do_load(vecs[i].bin, vecs[i].ld, {vecs[i].name, "_load"});
            do_tick(vecs[i].tk, {vecs[i].name, "_tick"});
        end

        // Load coincident with a tick: load wins, tick discarded.
        clk1sec = 1'b1;
        step();
        do_load(mkbin(2022, 7, 4, 11, 22, 33), mk(2022, 7, 4, 11, 22, 33, 0, 0), "collide_load");
        sb_q.push_back(mk(2022, 7, 4, 11, 22, 33, 0, 0));
        step();
        check("collide_no_late_tick");
        clk1sec = 1'b0;
        step();
        step();

        // Pause: load still works, five rises ignored, no burst on release.
        pause = 1'b1;
        do_load(mkbin(2023, 6, 15, 8, 30, 0), mk(2023, 6, 15, 8, 30, 0, 0, 0), "pause_load");
        for (int i = 0; i < 5; i++) begin
            clk1sec = 1'b1;
            step();
            step();
            clk1sec = 1'b0;
            step();
            step();
        end
        sb_q.push_back(mk(2023, 6, 15, 8, 30, 0, 0, 0));
        check("pause_frozen");
        clk1sec = 1'b1;
        step();
        step();
        pause = 1'b0;
        step();
        sb_q.push_back(mk(2023, 6, 15, 8, 30, 0, 0, 0));
        check("pause_release_no_burst");
        clk1sec = 1'b0;
        step();
        step();
        do_tick(mk(2023, 6, 15, 8, 30, 1, 1, 0), "pause_first_tick");

        // Reset mid-operation discards a pending tick.
        clk1sec = 1'b1;
        step();
        rst = 1'b1;
        clk1sec = 1'b0;
        sb_q.push_back(mk(2000, 1, 1, 0, 0, 0, 0, 0));
        step();
        rst = 1'b0;
        check("reset_mid");
        sb_q.push_back(mk(2000, 1, 1, 0, 0, 0, 0, 0));
        step();
        step();
        check("reset_mid_no_tick");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
